// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM encoding, matrix size
// and the key-index to hex-code map.
package keypad_pkg;

   localparam int NUM_COLS = 4;
   localparam int NUM_ROWS = 4;
   localparam int NUM_KEYS = NUM_COLS * NUM_ROWS;

   typedef enum logic {
      ARMED = 1'b0,
      HELD  = 1'b1
   } scan_state_t;

   // Entry i (index = col*4 + row) lives in bits [i*4 +: 4].
   localparam logic [4*NUM_KEYS-1:0] KEY_MAP = 64'hDCBA_E963_F852_0741;

   function automatic logic [3:0] key_lookup(input logic [3:0] idx);
      return KEY_MAP[{idx, 2'b00} +: 4];
   endfunction

   function automatic logic [3:0] onehot_index(input logic [NUM_KEYS-1:0] v);
      logic [3:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (v[i]) begin
            idx = idx | 4'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/sync2.sv
// Generic-width two-flop synchronizer with asynchronous active-low reset.
module sync2 #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_reg <= '0;
         sync_reg <= '0;
      end else begin
         meta_reg <= d;
         sync_reg <= meta_reg;
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, whole-keypad snapshot debounce, single-key
// event FSM and a valid/ack handshake towards the SoC.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 100000,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_code,
   output logic       key_valid,
   input  logic       key_ack,
   output logic       key_overrun,
   output logic       key_down
);

   localparam int                SLOT_W    = $clog2(SCAN_DIV);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam int                STAB_W    = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS) : 1;
   localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(DEBOUNCE_SCANS - 1);
   localparam logic [1:0]        COL_LAST  = 2'(NUM_COLS - 1);

   logic [NUM_ROWS-1:0] sync_row_n;
   logic [NUM_ROWS-1:0] row;

   logic [SLOT_W-1:0]   slot_reg, slot_next;
   logic [1:0]          col_reg, col_next;
   logic                slot_last;
   logic                scan_done;

   logic [NUM_KEYS-1:0] snap_reg, snap_next;
   logic [NUM_KEYS-1:0] prev_snap_reg, prev_snap_next;
   logic [STAB_W-1:0]   stable_reg, stable_next;
   logic                accepted;
   logic                snap_any;
   logic                snap_onehot;

   scan_state_t         state_reg, state_next;
   logic                emit;

   logic [3:0]          key_code_reg, key_code_next;
   logic                key_valid_reg, key_valid_next;
   logic                key_overrun_reg, key_overrun_next;
   logic                key_down_reg, key_down_next;

   sync2 #(
      .WIDTH (NUM_ROWS)
   ) u_row_sync (
      .clk   (clk),
      .rst_n (rst),
      .d     (row_n),
      .q     (sync_row_n)
   );

   assign row = ~sync_row_n;

   assign slot_last = (slot_reg == SLOT_LAST);
   assign scan_done = slot_last && (col_reg == COL_LAST);
   assign slot_next = slot_last ? '0 : slot_reg + 1'b1;
   assign col_next  = slot_last ? col_reg + 2'd1 : col_reg;

   // One column driven low at a time; each column's nibble of the snapshot
   // is refreshed from the rows on the last cycle of its slot.
   generate
      for (genvar gi = 0; gi < NUM_COLS; gi++) begin : g_col
         assign col_n[gi] = (col_reg != 2'(gi));
         assign snap_next[gi*NUM_ROWS +: NUM_ROWS] =
            (slot_last && (col_reg == 2'(gi))) ? row : snap_reg[gi*NUM_ROWS +: NUM_ROWS];
      end
   endgenerate

   // Debounce operates on the snapshot including the column written this cycle.
   always_comb begin
      stable_next    = stable_reg;
      prev_snap_next = prev_snap_reg;
      if (scan_done) begin
         if (snap_next == prev_snap_reg) begin
            stable_next = (stable_reg == STAB_MAX) ? STAB_MAX : stable_reg + 1'b1;
         end else begin
            stable_next = '0;
         end
         prev_snap_next = snap_next;
      end
   end

   assign accepted    = scan_done && (stable_next == STAB_MAX);
   assign snap_any    = |snap_next;
   assign snap_onehot = snap_any && ((snap_next & (snap_next - 1'b1)) == '0);

   always_comb begin
      state_next = state_reg;
      emit       = 1'b0;
      if (accepted) begin
         case (state_reg)
            ARMED: begin
               if (snap_onehot) begin
                  emit       = 1'b1;
                  state_next = HELD;
               end else if (snap_any) begin
                  state_next = HELD;
               end
            end
            HELD: begin
               if (!snap_any) begin
                  state_next = ARMED;
               end
            end
            default: state_next = ARMED;
         endcase
      end
   end

   // A new event always wins the code register; an ack in the same cycle
   // only clears the overrun flag, so the fresh event stays valid.
   always_comb begin
      key_code_next    = key_code_reg;
      key_valid_next   = key_valid_reg;
      key_overrun_next = key_overrun_reg;
      key_down_next    = key_down_reg;
      if (key_ack && key_valid_reg) begin
         key_valid_next   = 1'b0;
         key_overrun_next = 1'b0;
      end
      if (emit) begin
         key_code_next  = key_lookup(onehot_index(snap_next));
         key_valid_next = 1'b1;
         if (key_valid_reg && !key_ack) begin
            key_overrun_next = 1'b1;
         end
      end
      if (accepted) begin
         key_down_next = snap_any;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_reg      <= '0;
         col_reg       <= '0;
         snap_reg      <= '0;
         prev_snap_reg <= '0;
         stable_reg    <= '0;
      end else begin
         slot_reg      <= slot_next;
         col_reg       <= col_next;
         snap_reg      <= snap_next;
         prev_snap_reg <= prev_snap_next;
         stable_reg    <= stable_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= ARMED;
      end else begin
         state_reg <= state_next;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_code_reg    <= '0;
         key_valid_reg   <= 1'b0;
         key_overrun_reg <= 1'b0;
         key_down_reg    <= 1'b0;
      end else begin
         key_code_reg    <= key_code_next;
         key_valid_reg   <= key_valid_next;
         key_overrun_reg <= key_overrun_next;
         key_down_reg    <= key_down_next;
      end
   end

   assign key_code    = key_code_reg;
   assign key_valid   = key_valid_reg;
   assign key_overrun = key_overrun_reg;
   assign key_down    = key_down_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_SCANS=2
// (16-cycle scan) and a behavioural key-matrix model driving row_n.
module tb_keypad_scanner;

   logic        clk;
   logic        rst;
   logic [3:0]  row_n;
   logic [3:0]  col_n;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ack;
   logic        key_overrun;
   logic        key_down;

   logic [15:0] keys;
   int          cyc;
   int          n_checks;
   int          n_fail;

   typedef struct {
      logic [15:0] keys;
      bit          ack;
      int          scans;
      logic [3:0]  code;
      bit          valid;
      bit          ovr;
      bit          down;
   } vec_t;

   vec_t       vecs [15];
   logic [3:0] exp_map [16];

   keypad_scanner #(
      .SCAN_DIV       (4),
      .DEBOUNCE_SCANS (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .row_n       (row_n),
      .col_n       (col_n),
      .key_code    (key_code),
      .key_valid   (key_valid),
      .key_ack     (key_ack),
      .key_overrun (key_overrun),
      .key_down    (key_down)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pressed key at (col, row) pulls that row low while its column is driven.
   always_comb begin
      row_n = 4'hF;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            if (!col_n[c] && keys[c*4 + r]) begin
               row_n[r] = 1'b0;
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic check_out(input string tag, input logic [3:0] code, input bit valid,
                            input bit ovr, input bit down);
      check({tag, ".code"},    16'(key_code),    16'(code));
      check({tag, ".valid"},   16'(key_valid),   16'(valid));
      check({tag, ".overrun"}, 16'(key_overrun), 16'(ovr));
      check({tag, ".down"},    16'(key_down),    16'(down));
      $display("txn %-12s cyc=%0d keys=%h code=%h valid=%b ovr=%b down=%b",
               tag, cyc, keys, key_code, key_valid, key_overrun, key_down);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic to_boundary();
      do step(); while (cyc % 16 != 0);
   endtask

   task automatic pulse_ack();
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{16'h0020, 1'b0, 3, 4'h5, 1'b1, 1'b0, 1'b1};
      vecs[1]  = '{16'h0020, 1'b1, 1, 4'h5, 1'b0, 1'b0, 1'b1};
      vecs[2]  = '{16'h0000, 1'b0, 2, 4'h5, 1'b0, 1'b0, 1'b0};
      vecs[3]  = '{16'h1001, 1'b0, 1, 4'h5, 1'b0, 1'b0, 1'b0};
      vecs[4]  = '{16'h1001, 1'b0, 1, 4'h5, 1'b0, 1'b0, 1'b1};
      vecs[5]  = '{16'h1001, 1'b0, 2, 4'h5, 1'b0, 1'b0, 1'b1};
      vecs[6]  = '{16'h0000, 1'b0, 2, 4'h5, 1'b0, 1'b0, 1'b0};
      vecs[7]  = '{16'h8000, 1'b0, 2, 4'hD, 1'b1, 1'b0, 1'b1};
      vecs[8]  = '{16'h8000, 1'b1, 1, 4'hD, 1'b0, 1'b0, 1'b1};
      vecs[9]  = '{16'h0000, 1'b0, 2, 4'hD, 1'b0, 1'b0, 1'b0};
      vecs[10] = '{16'h0100, 1'b0, 2, 4'h3, 1'b1, 1'b0, 1'b1};
      vecs[11] = '{16'h0000, 1'b0, 2, 4'h3, 1'b1, 1'b0, 1'b0};
      vecs[12] = '{16'h0004, 1'b0, 2, 4'h7, 1'b1, 1'b1, 1'b1};
      vecs[13] = '{16'h0004, 1'b1, 1, 4'h7, 1'b0, 1'b0, 1'b1};
      vecs[14] = '{16'h0000, 1'b0, 2, 4'h7, 1'b0, 1'b0, 1'b0};
      exp_map = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                  4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};

      n_checks = 0;
      n_fail   = 0;
      cyc      = 0;
      keys     = '0;
      key_ack  = 1'b0;
      rst      = 1'b0;
      repeat (3) step();
      check("rst.col_n", 16'(col_n), 16'hE);
      check_out("reset", 4'h0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      cyc = 0;

      // Idle: column walks every 4 cycles, nothing reported.
      for (int i = 0; i < 64; i++) begin
         logic [3:0] exp_col;
         exp_col = 4'hF;
         exp_col[(cyc / 4) % 4] = 1'b0;
         check("idle.col_n", 16'(col_n), 16'(exp_col));
         check("idle.valid", 16'(key_valid), 16'h0);
         check("idle.down",  16'(key_down),  16'h0);
         step();
      end
      $display("txn idle        cyc=%0d 64 cycles checked", cyc);

      // Key 5: event appears exactly one cycle after the 2nd identical scan.
      keys = 16'h0020;
      to_boundary();
      repeat (15) step();
      check_out("k5.pre", 4'h0, 1'b0, 1'b0, 1'b0);
      step();
      check_out("k5.event", 4'h5, 1'b1, 1'b0, 1'b1);

      for (int v = 0; v < 15; v++) begin
         keys = vecs[v].keys;
         if (vecs[v].ack) pulse_ack();
         for (int s = 0; s < vecs[v].scans; s++) to_boundary();
         check_out($sformatf("vec%0d", v), vecs[v].code, vecs[v].valid,
                   vecs[v].ovr, vecs[v].down);
      end

      // Second event lands together with an ack: stays valid, no overrun.
      keys = 16'h0100;
      to_boundary();
      to_boundary();
      check_out("sa.k3", 4'h3, 1'b1, 1'b0, 1'b1);
      keys = 16'h0000;
      to_boundary();
      to_boundary();
      keys = 16'h0004;
      to_boundary();
      repeat (15) step();
      key_ack = 1'b1;
      step();
      key_ack = 1'b0;
      check_out("sa.k7", 4'h7, 1'b1, 1'b0, 1'b1);
      pulse_ack();
      check_out("sa.ack", 4'h7, 1'b0, 1'b0, 1'b1);
      keys = 16'h0000;
      to_boundary();
      to_boundary();

      // Key 9 bouncing every 3 cycles for 40 cycles, then held.
      for (int i = 0; i < 40; i++) begin
         keys = (((i / 3) % 2) == 0) ? 16'h0400 : 16'h0000;
         step();
         if (cyc % 16 == 0) check_out("bounce", 4'h7, 1'b0, 1'b0, key_down);
      end
      keys = 16'h0400;
      to_boundary();
      check_out("k9.event", 4'h9, 1'b1, 1'b0, 1'b1);
      to_boundary();
      to_boundary();
      check_out("k9.held", 4'h9, 1'b1, 1'b0, 1'b1);
      pulse_ack();
      keys = 16'h0000;
      to_boundary();
      to_boundary();

      // Full key-map sweep, one key at a time.
      for (int k = 0; k < 16; k++) begin
         keys = 16'h0001 << k;
         to_boundary();
         to_boundary();
         check_out($sformatf("map%0d", k), exp_map[k], 1'b1, 1'b0, 1'b1);
         pulse_ack();
         keys = 16'h0000;
         to_boundary();
         to_boundary();
      end

      // Reset mid column 2 with E pending, E still held afterwards.
      keys = 16'h0800;
      to_boundary();
      to_boundary();
      check_out("kE.pend", 4'hE, 1'b1, 1'b0, 1'b1);
      repeat (9) step();
      rst = 1'b0;
      #1;
      check("rstE.col_n", 16'(col_n), 16'hE);
      check_out("rstE.now", 4'h0, 1'b0, 1'b0, 1'b0);
      repeat (3) step();
      rst = 1'b1;
      cyc = 0;
      to_boundary();
      check_out("rstE.scan1", 4'h0, 1'b0, 1'b0, 1'b0);
      to_boundary();
      check_out("rstE.scan2", 4'hE, 1'b1, 1'b0, 1'b1);
      to_boundary();
      check_out("rstE.held", 4'hE, 1'b1, 1'b0, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
